// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply, restoring divide.
// One iteration per clock; results land in hi/lo with a busy/done handshake.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mult,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] low_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] low_d;
    logic             accept;
    logic             last;

    assign accept = start & (mult | div);
    assign last   = (cnt_q == CW'(WIDTH - 1));

    // opb_q holds the multiplicand or the divisor; low_q the multiplier or dividend
    always_comb begin
        addend   = low_q[0] ? {1'b0, opb_q} : '0;
        mul_sum  = {1'b0, acc_q} + addend;
        div_rem  = {acc_q, low_q[WIDTH-1]};
        div_diff = div_rem - {1'b0, opb_q};
        acc_d    = acc_q;
        low_d    = low_q;
        if (state_q == MUL) begin
            acc_d = mul_sum[WIDTH:1];
            low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        end else if (state_q == DIV) begin
            acc_d = div_diff[WIDTH] ? div_rem[WIDTH-1:0] : div_diff[WIDTH-1:0];
            low_d = {low_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            low_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        opb_q   <= mult ? a : b;
                        low_q   <= mult ? b : a;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= mult ? MUL : DIV;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MUL, DIV: begin
                    acc_q <= acc_d;
                    low_q <= low_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        hi_q    <= acc_d;
                        lo_q    <= low_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected hi/lo queued at issue,
// popped and compared when done pulses.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mult;
    logic         div;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_v;
    logic [2*W-1:0] got_v;
    int             vectors = 0;
    int             errs = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mult(mult), .div(div),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy === 1'b1 && done === 1'b1) begin
            errs++;
            $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1", busy, done);
        end
    end

    function automatic logic [2*W-1:0] model(input logic m, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        if (m) return {{W{1'b0}}, x} * {{W{1'b0}}, y};
        if (y == '0) return {x, {W{1'b1}}};
        return {x % y, x / y};
    endfunction

    task automatic issue(input logic m, input logic d, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; mult = m; div = d; a = x; b = y;
        if (m | d) exp_q.push_back(model(m, x, y));
        @(negedge clk);
        start = 1'b0; mult = 1'b0; div = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit gap);
        n = 0;
        gap = 1'b0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (done !== 1'b1 && busy !== 1'b1) gap = 1'b1;
        end
    endtask

    task automatic pop_exp();
        exp_v = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mult = 1'b0; div = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, hi, lo} !== '0) begin
            errs++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h required all 0",
                     busy, done, hi, lo);
        end
        rst = 1'b0;
    endtask

    task automatic test_ops(input string tag, input logic m, input logic d,
                            input logic [W-1:0] xs[], input logic [W-1:0] ys[]);
        int n;
        bit gap;
        for (int i = 0; i < xs.size(); i++) begin
            issue(m, d, xs[i], ys[i]);
            vectors++;
            if (busy !== 1'b1) begin
                errs++;
                $display("FAIL %s_busy_rise[%0d]: busy=%b required 1", tag, i, busy);
            end
            wait_done(n, gap);
            vectors++;
            if (n != W || gap) begin
                errs++;
                $display("FAIL %s_latency[%0d]: cycles=%0d gap=%b required %0d gap=0",
                         tag, i, n, gap, W);
            end
            vectors++;
            if (busy !== 1'b0) begin
                errs++;
                $display("FAIL %s_busy_in_done[%0d]: busy=%b required 0", tag, i, busy);
            end
            pop_exp();
            got_v = {hi, lo};
            vectors++;
            if (got_v !== exp_v) begin
                errs++;
                $display("FAIL %s_result[%0d]: hi:lo=%h required %h", tag, i, got_v, exp_v);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || {hi, lo} !== exp_v) begin
                errs++;
                $display("FAIL %s_done_pulse_hold[%0d]: done=%b hi:lo=%h required 0 %h",
                         tag, i, done, {hi, lo}, exp_v);
            end
        end
    endtask

    task automatic test_nop();
        logic [2*W-1:0] held;
        held = exp_v;
        @(negedge clk);
        start = 1'b1; mult = 1'b0; div = 1'b0; a = 32'd99; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL nop_busy: busy=%b required 0", busy);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== held) begin
            errs++;
            $display("FAIL nop_hold: busy=%b done=%b hi:lo=%h required 0 0 %h",
                     busy, done, {hi, lo}, held);
        end
    endtask

    task automatic test_midop();
        int n;
        bit gap;
        issue(1'b1, 1'b0, 32'd5, 32'd5);
        repeat (5) @(negedge clk);
        start = 1'b1; mult = 1'b0; div = 1'b1; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0; div = 1'b0; a = $urandom; b = $urandom;
        wait_done(n, gap);
        vectors++;
        if (n != W - 6 || gap) begin
            errs++;
            $display("FAIL midop_latency: cycles=%0d gap=%b required %0d gap=0", n, gap, W - 6);
        end
        pop_exp();
        got_v = {hi, lo};
        vectors++;
        if (got_v !== exp_v) begin
            errs++;
            $display("FAIL midop_result: hi:lo=%h required %h", got_v, exp_v);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || exp_q.size() != 0) begin
            errs++;
            $display("FAIL midop_no_second: busy=%b done=%b pending=%0d required 0 0 0",
                     busy, done, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit gap;
        issue(1'b1, 1'b0, 32'd11, 32'd13);
        wait_done(n, gap);
        pop_exp();
        got_v = {hi, lo};
        vectors++;
        if (got_v !== exp_v) begin
            errs++;
            $display("FAIL b2b_first: hi:lo=%h required %h", got_v, exp_v);
        end
        start = 1'b1; mult = 1'b0; div = 1'b1; a = 32'd20; b = 32'd6;
        exp_q.push_back(model(1'b0, 32'd20, 32'd6));
        @(negedge clk);
        start = 1'b0; div = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errs++;
            $display("FAIL b2b_accept: busy=%b done=%b required 1 0", busy, done);
        end
        wait_done(n, gap);
        vectors++;
        if (n != W || gap) begin
            errs++;
            $display("FAIL b2b_latency: cycles=%0d gap=%b required %0d gap=0", n, gap, W);
        end
        pop_exp();
        got_v = {hi, lo};
        vectors++;
        if (got_v !== {32'd2, 32'd3} || got_v !== exp_v) begin
            errs++;
            $display("FAIL b2b_div: hi:lo=%h required %h", got_v, exp_v);
        end
    endtask

    task automatic test_reset_midop();
        int n;
        bit gap;
        bit seen;
        issue(1'b1, 1'b0, 32'd123456, 32'd789);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, hi, lo} !== '0) begin
            errs++;
            $display("FAIL rst_midop_state: busy=%b done=%b hi=%h lo=%h required all 0",
                     busy, done, hi, lo);
        end
        rst = 1'b0;
        void'(exp_q.pop_back());
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            errs++;
            $display("FAIL rst_midop_quiet: activity=%b required 0", seen);
        end
        issue(1'b1, 1'b0, 32'd2, 32'd3);
        wait_done(n, gap);
        pop_exp();
        got_v = {hi, lo};
        vectors++;
        if (n != W || got_v !== 64'd6) begin
            errs++;
            $display("FAIL rst_midop_recover: cycles=%0d hi:lo=%h required %0d %h",
                     n, got_v, W, 64'd6);
        end
    endtask

    initial begin
        logic [W-1:0] mx[];
        logic [W-1:0] my[];
        test_reset();
        mx = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0};
        my = '{32'd6, 32'hFFFF_FFFF, 32'h0001_2345, 32'hDEAD_BEEF};
        test_ops("mul", 1'b1, 1'b0, mx, my);
        mx = '{32'd100, 32'd1234, 32'hFFFF_FFFF, 32'd5};
        my = '{32'd7, 32'd0, 32'd1, 32'd9};
        test_ops("div", 1'b0, 1'b1, mx, my);
        test_nop();
        test_midop();
        mx = '{32'd3};
        my = '{32'd4};
        test_ops("both", 1'b1, 1'b1, mx, my);
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
